// File: rtl/cic_interpolate_mc_if.sv
// rtl/cic_interpolate_mc_if.sv - input/output sample streams of the multi-channel CIC interpolator
// master drives input samples and output backpressure; slave is the filter.
interface cic_interpolate_mc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2
);
  logic [NUM_CH*DATA_WIDTH-1:0] in_tdata;
  logic                         in_tvalid;
  logic                         in_tready;
  logic [NUM_CH*DATA_WIDTH-1:0] out_tdata;
  logic                         out_tvalid;
  logic                         out_tready;
  logic                         out_tlast;

  modport master (
    output in_tdata, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tvalid, out_tlast
  );

  modport slave (
    input  in_tdata, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tvalid, out_tlast
  );
endinterface

// File: rtl/cic_interpolate_mc.sv
// rtl/cic_interpolate_mc.sv - NUM_CH-channel CIC interpolator, N stages, runtime rate 1..MAX_RATE
// One shared control path; combs run at the input rate, integrators once per output beat.
module cic_interpolate_mc #(
  parameter int  DATA_WIDTH = 16,
  parameter int  NUM_CH     = 2,
  parameter int  N          = 4,
  parameter int  MAX_RATE   = 128,
  localparam int RW         = $clog2(MAX_RATE + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clear_i,
  input  logic                rate_stb_i,
  input  logic [RW-1:0]       rate_i,
  cic_interpolate_mc_if.slave s_if
);
  localparam int ACC_WIDTH = DATA_WIDTH + N + (N - 1) * $clog2(MAX_RATE);
  localparam int SW        = 8;
  localparam logic [SW-1:0] NM1 = SW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  state_t                       state_q;
  logic [RW-1:0]                active_q, pending_q, cnt_q;
  logic                         first_q;
  acc_t                         dly_q   [NUM_CH][N];
  acc_t                         integ_q [NUM_CH][N];
  acc_t                         comb_q  [NUM_CH];
  logic [NUM_CH*DATA_WIDTH-1:0] out_tdata_q;
  logic                         out_tvalid_q, out_tlast_q;

  acc_t                         comb_x  [NUM_CH][N+1];
  acc_t                         integ_d [NUM_CH][N];
  logic [NUM_CH*DATA_WIDTH-1:0] out_tdata_d;
  logic [RW-1:0]                rate_clamped, rate_next;
  logic [SW-1:0]                shift_amt;
  logic                         advance, accept, rate_change;

  function automatic logic [SW-1:0] ceil_log2(input logic [RW-1:0] r);
    logic [SW-1:0] res;
    res = '0;
    for (int i = 0; i < RW; i++) begin
      if (r > (RW'(1) << i)) res = SW'(i + 1);
    end
    return res;
  endfunction

  assign rate_clamped = (rate_i == '0) ? RW'(1) :
                        (rate_i > RW'(MAX_RATE)) ? RW'(MAX_RATE) : rate_i;
  assign rate_change  = (pending_q != active_q);
  assign rate_next    = rate_change ? pending_q : active_q;
  assign shift_amt    = NM1 * ceil_log2(active_q);

  // in_tready depends on out_tready so a new sample can follow the last beat without a bubble
  assign advance        = (state_q == RUN) && (!out_tvalid_q || s_if.out_tready);
  assign s_if.in_tready = reset_n_i && !clear_i &&
                          ((state_q == IDLE) || (advance && (cnt_q == '0)));
  assign accept         = s_if.in_tvalid && s_if.in_tready;

  assign s_if.out_tdata  = out_tdata_q;
  assign s_if.out_tvalid = out_tvalid_q;
  assign s_if.out_tlast  = out_tlast_q;

  // A rate change restarts the filter, so the combs see zeroed delays for that sample
  always_comb begin
    out_tdata_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      comb_x[c][0] = {{(ACC_WIDTH-DATA_WIDTH){s_if.in_tdata[c*DATA_WIDTH+DATA_WIDTH-1]}},
                      s_if.in_tdata[c*DATA_WIDTH +: DATA_WIDTH]};
      for (int k = 0; k < N; k++) begin
        comb_x[c][k+1] = comb_x[c][k] - (rate_change ? acc_t'(0) : dly_q[c][k]);
      end
      integ_d[c][0] = integ_q[c][0] + (first_q ? comb_q[c] : acc_t'(0));
      for (int k = 1; k < N; k++) begin
        integ_d[c][k] = integ_q[c][k] + integ_d[c][k-1];
      end
      out_tdata_d[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(integ_d[c][N-1] >>> shift_amt);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      active_q     <= RW'(1);
      pending_q    <= RW'(1);
      cnt_q        <= '0;
      first_q      <= 1'b0;
      out_tdata_q  <= '0;
      out_tvalid_q <= 1'b0;
      out_tlast_q  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        comb_q[c] <= '0;
        for (int k = 0; k < N; k++) begin
          dly_q[c][k]   <= '0;
          integ_q[c][k] <= '0;
        end
      end
    end else begin
      if (rate_stb_i) pending_q <= rate_clamped;
      if (clear_i) begin
        state_q      <= IDLE;
        cnt_q        <= '0;
        first_q      <= 1'b0;
        out_tvalid_q <= 1'b0;
        out_tlast_q  <= 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
          comb_q[c] <= '0;
          for (int k = 0; k < N; k++) begin
            dly_q[c][k]   <= '0;
            integ_q[c][k] <= '0;
          end
        end
      end else begin
        if (advance) begin
          for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < N; k++) integ_q[c][k] <= integ_d[c][k];
          end
          out_tdata_q  <= out_tdata_d;
          out_tvalid_q <= 1'b1;
          out_tlast_q  <= (cnt_q == '0);
          cnt_q        <= cnt_q - 1'b1;
          first_q      <= 1'b0;
          if (cnt_q == '0) state_q <= IDLE;
        end else if (s_if.out_tready) begin
          out_tvalid_q <= 1'b0;
        end
        // The final beat of the old burst is already registered above before state is wiped
        if (accept) begin
          if (rate_change) begin
            active_q <= pending_q;
            for (int c = 0; c < NUM_CH; c++) begin
              for (int k = 0; k < N; k++) integ_q[c][k] <= '0;
            end
          end
          for (int c = 0; c < NUM_CH; c++) begin
            comb_q[c] <= comb_x[c][N];
            for (int k = 0; k < N; k++) dly_q[c][k] <= comb_x[c][k];
          end
          cnt_q   <= rate_next - 1'b1;
          first_q <= 1'b1;
          state_q <= RUN;
        end
      end
    end
  end
endmodule

// File: tb/tb_cic_interpolate_mc.sv
// tb/tb_cic_interpolate_mc.sv - bench for cic_interpolate_mc
// Reference: CIC response as N-fold convolution of a length-R box over the zero-stuffed input.
module tb_cic_interpolate_mc;
  localparam int DW = 16;
  localparam int NC = 2;
  localparam int NS = 4;
  localparam int MR = 128;
  localparam int RW = $clog2(MR + 1);

  typedef struct {
    logic [NC*DW-1:0] data;
    logic             last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          rate_stb = 1'b0;
  logic [RW-1:0] rate = '0;

  cic_interpolate_mc_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus ();

  cic_interpolate_mc #(.DATA_WIDTH(DW), .NUM_CH(NC), .N(NS), .MAX_RATE(MR)) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .clear_i    (clear),
    .rate_stb_i (rate_stb),
    .rate_i     (rate),
    .s_if       (bus.slave)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_fail = 0;
  beat_t            exp_q[$];
  logic [NC*DW-1:0] hist[$];
  logic [NC*DW-1:0] src[$];
  logic [NC*DW-1:0] got[$];
  int               m_active, m_pending;
  int               beats, lasts, accepts, cyc, first_cyc, last_cyc;
  logic             hold_v = 1'b0;
  logic [NC*DW-1:0] hold_d;
  logic             hold_l;
  logic [NC*DW-1:0] w;
  int               imp[6] = '{1024, 4096, 6144, 4096, 1024, 0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int clamp(input int r);
    return (r == 0) ? 1 : ((r > MR) ? MR : r);
  endfunction

  function automatic longint sample_of(input logic [NC*DW-1:0] x, input int c);
    logic signed [DW-1:0] s;
    s = x[c*DW +: DW];
    return longint'(s);
  endfunction

  function automatic void gen_beats();
    longint h[$], t[$];
    longint acc, s, v;
    int r, sh;
    logic [NC*DW-1:0] d;
    beat_t b;
    r = m_active;
    sh = 0;
    while ((1 << sh) < r) sh++;
    sh = sh * (NS - 1);
    h.push_back(1);
    repeat (NS) begin
      t.delete();
      for (int k = 0; k < h.size() + r - 1; k++) begin
        s = 0;
        for (int m = 0; m < r; m++) if (k - m >= 0 && k - m < h.size()) s += h[k-m];
        t.push_back(s);
      end
      h = t;
    end
    for (int j = 0; j < r; j++) begin
      d = '0;
      for (int c = 0; c < NC; c++) begin
        acc = 0;
        for (int i = 0; i < hist.size(); i++)
          if (i * r + j < h.size()) acc += h[i*r+j] * sample_of(hist[i], c);
        v = acc >>> sh;
        d[c*DW +: DW] = v[DW-1:0];
      end
      b.data = d;
      b.last = (j == r - 1);
      exp_q.push_back(b);
    end
  endfunction

  function automatic void model_accept(input logic [NC*DW-1:0] x);
    accepts++;
    if (m_pending != m_active) begin
      m_active = m_pending;
      hist.delete();
    end
    hist.push_front(x);
    if (hist.size() > NS) void'(hist.pop_back());
    gen_beats();
  endfunction

  // Evaluate one cycle mid-period, then advance to the next falling edge.
  task automatic step();
    beat_t e;
    #1;
    cyc++;
    if (hold_v) begin
      check("stall_valid", bus.out_tvalid, 1'b1);
      check("stall_data", bus.out_tdata, hold_d);
      check("stall_last", bus.out_tlast, hold_l);
    end
    if (bus.out_tvalid && bus.out_tready) begin
      beats++;
      got.push_back(bus.out_tdata);
      if (bus.out_tlast) lasts++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      check("beat_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data", bus.out_tdata, e.data);
        check("out_last", bus.out_tlast, e.last);
      end
    end
    hold_v = bus.out_tvalid && !bus.out_tready;
    hold_d = bus.out_tdata;
    hold_l = bus.out_tlast;
    if (clear) begin
      if (bus.in_tvalid) check("clear_blocks_input", bus.in_tready, 1'b0);
      exp_q.delete();
      hist.delete();
      hold_v = 1'b0;
    end else if (bus.in_tvalid && bus.in_tready) begin
      model_accept(bus.in_tdata);
    end
    if (rate_stb) m_pending = clamp(int'(rate));
    @(negedge clk);
  endtask

  task automatic set_rate(input int r);
    rate_stb = 1'b1;
    rate = RW'(r);
    step();
    rate_stb = 1'b0;
  endtask

  task automatic feed(input int pv, input int pr);
    int idx;
    int guard;
    int a0;
    idx = 0;
    guard = 0;
    while (idx < src.size() && guard < 5000) begin
      bus.in_tvalid  = ($urandom_range(99) < pv);
      bus.in_tdata   = src[idx];
      bus.out_tready = ($urandom_range(99) < pr);
      a0 = accepts;
      step();
      if (accepts != a0) idx++;
      guard++;
    end
    bus.in_tvalid = 1'b0;
    check("feed_done", idx, src.size());
  endtask

  task automatic drain(input int pr);
    int guard;
    guard = 0;
    bus.in_tvalid = 1'b0;
    while ((exp_q.size() != 0 || bus.out_tvalid) && guard < 3000) begin
      bus.out_tready = ($urandom_range(99) < pr);
      step();
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic start_phase();
    beats = 0;
    lasts = 0;
    first_cyc = -1;
    last_cyc = -1;
    got.delete();
    src.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    bus.in_tvalid  = 1'b0;
    bus.in_tdata   = '0;
    bus.out_tready = 1'b0;
    m_active = 1;
    m_pending = 1;
    accepts = 0;
    cyc = 0;
    #1;
    check("rst_tvalid", bus.out_tvalid, 1'b0);
    check("rst_tdata", bus.out_tdata, 0);
    check("rst_tlast", bus.out_tlast, 1'b0);
    check("rst_tready", bus.in_tready, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("idle_tready", bus.in_tready, 1'b1);

    // DC at rate 4
    set_rate(4);
    start_phase();
    for (int i = 0; i < 20; i++) src.push_back({16'd1000, 16'd1000});
    feed(100, 100);
    drain(100);
    check("dc_beats", beats, 80);
    check("dc_lasts", lasts, 20);
    check("dc_one_per_clk", last_cyc - first_cyc, 79);
    check("dc_settled", got[got.size()-1], {16'd1000, 16'd1000});

    // Impulse at rate 2
    set_rate(2);
    start_phase();
    src.push_back({16'd0, 16'd8192});
    for (int i = 0; i < 5; i++) src.push_back('0);
    feed(100, 100);
    drain(100);
    check("imp_beats", beats, 12);
    for (int i = 0; i < 6; i++) begin
      w = got[i];
      check("imp_ch0", w[15:0], imp[i]);
      check("imp_ch1", w[31:16], 0);
    end

    // Backpressure at rate 8
    set_rate(8);
    start_phase();
    for (int i = 0; i < 12; i++) src.push_back($urandom());
    feed(70, 50);
    drain(50);
    check("bp_beats", beats, 96);
    check("bp_lasts", lasts, 12);

    // Rate change mid-burst
    set_rate(4);
    start_phase();
    src.push_back($urandom());
    bus.out_tready = 1'b1;
    feed(100, 100);
    step();
    set_rate(16);
    drain(100);
    check("rc_old_beats", beats, 4);
    check("rc_old_lasts", lasts, 1);
    start_phase();
    src.push_back({16'd0, 16'd4096});
    src.push_back($urandom());
    src.push_back($urandom());
    feed(100, 100);
    drain(100);
    check("rc_new_beats", beats, 48);
    w = got[0];
    check("rc_new_first", w[15:0], 1);

    // Rate clamps
    set_rate(0);
    start_phase();
    for (int i = 0; i < 4; i++) src.push_back($urandom());
    feed(100, 100);
    drain(100);
    check("r1_beats", beats, 4);
    for (int i = 0; i < 4; i++) check("r1_passthru", got[i], src[i]);
    set_rate(200);
    start_phase();
    src.push_back($urandom());
    src.push_back($urandom());
    feed(100, 100);
    drain(100);
    check("r128_beats", beats, 256);
    check("r128_lasts", lasts, 2);

    // Reset mid-burst
    set_rate(8);
    start_phase();
    src.push_back($urandom());
    feed(100, 100);
    g = 0;
    while (beats < 3 && g < 20) begin step(); g++; end
    check("rst_reached_beat3", beats, 3);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_tvalid", bus.out_tvalid, 1'b0);
    check("mid_rst_tdata", bus.out_tdata, 0);
    check("mid_rst_tlast", bus.out_tlast, 1'b0);
    check("mid_rst_tready", bus.in_tready, 1'b0);
    m_active = 1;
    m_pending = 1;
    hist.delete();
    exp_q.delete();
    hold_v = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    start_phase();
    src.push_back($urandom());
    src.push_back($urandom());
    feed(100, 100);
    drain(100);
    check("post_rst_beats", beats, 2);
    check("post_rst_passthru", got[0], src[0]);

    // Clear mid-burst
    set_rate(8);
    start_phase();
    src.push_back($urandom());
    feed(100, 100);
    g = 0;
    while (beats < 3 && g < 20) begin step(); g++; end
    check("clr_reached_beat3", beats, 3);
    clear = 1'b1;
    bus.in_tvalid = 1'b1;
    bus.in_tdata = $urandom();
    step();
    clear = 1'b0;
    bus.in_tvalid = 1'b0;
    #1 check("clr_tvalid", bus.out_tvalid, 1'b0);
    start_phase();
    src.push_back({16'h1234, 16'd8192});
    feed(100, 100);
    drain(100);
    check("clr_beats", beats, 8);
    w = got[0];
    check("clr_fresh_first", w[15:0], 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
